// File: rtl/bus_err_drain_arbiter.sv
// bus_err_drain_arbiter
// Round-robin drain of per-unit error FIFOs into a single valid/ready report
// stream. The winning unit is popped in the grant cycle and its head record is
// held in output registers until the consumer accepts it. Also keeps sticky
// per-unit overflow flags and a saturating count of accepted reports.
module bus_err_drain_arbiter #(
  parameter int unsigned NumUnits      = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned MetaDataWidth = 1,
  parameter int unsigned ErrBits       = 3,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned IdxWidth      = (NumUnits > 1) ? $clog2(NumUnits) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumUnits-1:0]                     unit_mask_i,
  input  logic [NumUnits-1:0]                     src_irq_i,
  input  logic [NumUnits-1:0][ErrBits-1:0]        src_code_i,
  input  logic [NumUnits-1:0][AddrWidth-1:0]      src_addr_i,
  input  logic [NumUnits-1:0][MetaDataWidth-1:0]  src_meta_i,
  input  logic [NumUnits-1:0]                     src_overflow_i,
  output logic [NumUnits-1:0]                     src_pop_o,
  output logic                                    rpt_valid_o,
  input  logic                                    rpt_ready_i,
  output logic [IdxWidth-1:0]                     rpt_unit_o,
  output logic [ErrBits-1:0]                      rpt_code_o,
  output logic [AddrWidth-1:0]                    rpt_addr_o,
  output logic [MetaDataWidth-1:0]                rpt_meta_o,
  output logic [NumUnits-1:0]                     ovf_sticky_o,
  input  logic [NumUnits-1:0]                     ovf_clear_i,
  output logic [CntWidth-1:0]                     rpt_cnt_o,
  input  logic                                    cnt_clear_i
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                      state_reg;
  state_t                      state_next;
  logic [NumUnits-1:0]         req;
  logic                        grant_found;
  logic [IdxWidth-1:0]         grant_idx;
  logic [IdxWidth-1:0]         cand;
  logic                        take;
  logic                        accept;
  logic [IdxWidth-1:0]         last_grant_reg;
  logic [IdxWidth-1:0]         unit_reg;
  logic [ErrBits-1:0]          code_reg;
  logic [AddrWidth-1:0]        addr_reg;
  logic [MetaDataWidth-1:0]    meta_reg;
  logic [NumUnits-1:0]         ovf_reg;
  logic [CntWidth-1:0]         cnt_reg;

  // Masked units never enter arbitration; the mask only matters in IDLE
  // because the grant is only acted on there.
  assign req = src_irq_i & ~unit_mask_i;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NumUnits; k++) begin
      cand = IdxWidth'((32'(last_grant_reg) + k) % NumUnits);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign take = (state_reg == IDLE) && grant_found;

  // Pop pulse is combinational so the FIFO advances in the grant cycle itself.
  for (genvar gi = 0; gi < NumUnits; gi++) begin : g_pop
    assign src_pop_o[gi] = take && (grant_idx == IdxWidth'(gi));
  end

  // Next-state logic: IDLE grants, HOLD waits for the consumer.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (grant_found) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (rpt_ready_i) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; a reset mid-HOLD drops the already-popped record.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the winner's head record and remember it for round-robin order.
  // last_grant starts at the top index so unit 0 wins first after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_reg <= IdxWidth'(NumUnits - 1);
      unit_reg       <= '0;
      code_reg       <= '0;
      addr_reg       <= '0;
      meta_reg       <= '0;
    end else if (take) begin
      last_grant_reg <= grant_idx;
      unit_reg       <= grant_idx;
      code_reg       <= src_code_i[grant_idx];
      addr_reg       <= src_addr_i[grant_idx];
      meta_reg       <= src_meta_i[grant_idx];
    end
  end

  // Sticky overflow flags; a same-cycle set beats the clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_reg <= '0;
    end else begin
      ovf_reg <= (ovf_reg & ~ovf_clear_i) | src_overflow_i;
    end
  end

  // Saturating accept counter; a clear beats a same-cycle accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (cnt_clear_i) begin
      cnt_reg <= '0;
    end else if (accept && (cnt_reg != {CntWidth{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  if (NumUnits == 1) begin : g_unit_tie
    assign rpt_unit_o = '0;
  end else begin : g_unit_reg
    assign rpt_unit_o = unit_reg;
  end

  assign rpt_valid_o  = (state_reg == HOLD);
  assign rpt_code_o   = code_reg;
  assign rpt_addr_o   = addr_reg;
  assign rpt_meta_o   = meta_reg;
  assign ovf_sticky_o = ovf_reg;
  assign rpt_cnt_o    = cnt_reg;

endmodule

// File: tb/tb_bus_err_drain_arbiter.sv
// Testbench for bus_err_drain_arbiter: directed steps from the test plan plus
// a randomized phase, all compared against a transaction-level model.
module tb_bus_err_drain_arbiter;

  localparam int N  = 4;
  localparam int AW = 48;
  localparam int EB = 3;
  localparam int MW = 1;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         mask;
  logic [N-1:0]         irq;
  logic [N-1:0][EB-1:0] code;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][MW-1:0] meta;
  logic [N-1:0]         ovf;
  logic [N-1:0]         pop;
  logic                 valid;
  logic                 ready;
  logic [1:0]           unit;
  logic [EB-1:0]        rcode;
  logic [AW-1:0]        raddr;
  logic [MW-1:0]        rmeta;
  logic [N-1:0]         sticky;
  logic [N-1:0]         ovf_clr;
  logic [CW-1:0]        cnt;
  logic                 cnt_clr;

  int checks = 0;
  int errors = 0;

  // Reference model state (transaction level)
  bit          m_hold;
  int          m_last;
  int          m_unit;
  logic [EB-1:0] m_code;
  logic [AW-1:0] m_addr;
  logic [MW-1:0] m_meta;
  int          m_cnt;
  logic [N-1:0] m_sticky;
  int          accq[$];

  bus_err_drain_arbiter #(
    .NumUnits(N), .AddrWidth(AW), .MetaDataWidth(MW), .ErrBits(EB), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .unit_mask_i(mask), .src_irq_i(irq),
    .src_code_i(code), .src_addr_i(addr), .src_meta_i(meta),
    .src_overflow_i(ovf), .src_pop_o(pop), .rpt_valid_o(valid),
    .rpt_ready_i(ready), .rpt_unit_o(unit), .rpt_code_o(rcode),
    .rpt_addr_o(raddr), .rpt_meta_o(rmeta), .ovf_sticky_o(sticky),
    .ovf_clear_i(ovf_clr), .rpt_cnt_o(cnt), .cnt_clear_i(cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_last = N - 1; m_unit = 0;
    m_code = '0; m_addr = '0; m_meta = '0;
    m_cnt = 0; m_sticky = '0;
  endtask

  task automatic randomize_heads();
    for (int i = 0; i < N; i++) begin
      code[i] = EB'($urandom);
      addr[i] = AW'({$urandom, $urandom});
      meta[i] = MW'($urandom);
    end
  endtask

  // One clock: check the combinational pop for the current inputs, advance
  // the model by one transaction step, then check registered outputs.
  task automatic cycle();
    logic [N-1:0] rq;
    logic [N-1:0] exp_pop;
    int  g;
    bit  acc;
    rq = irq & ~mask;
    #1;
    g = -1;
    exp_pop = '0;
    if (!m_hold) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && rq[(m_last + k) % N]) g = (m_last + k) % N;
      end
    end
    if (g >= 0) exp_pop[g] = 1'b1;
    chk("pop", 64'(pop), 64'(exp_pop));
    acc = m_hold && ready;
    if (acc) begin
      accq.push_back(m_unit);
      $display("accept unit=%0d code=%0h addr=%0h meta=%0h", m_unit, m_code, m_addr, m_meta);
      m_hold = 0;
    end
    if (g >= 0) begin
      m_hold = 1; m_unit = g; m_last = g;
      m_code = code[g]; m_addr = addr[g]; m_meta = meta[g];
    end
    if (cnt_clr) m_cnt = 0;
    else if (acc && m_cnt < (1 << CW) - 1) m_cnt++;
    m_sticky = (m_sticky & ~ovf_clr) | ovf;
    @(posedge clk);
    #1;
    chk("valid", 64'(valid), 64'(m_hold));
    chk("unit", 64'(unit), 64'(m_unit));
    chk("code", 64'(rcode), 64'(m_code));
    chk("addr", 64'(raddr), 64'(m_addr));
    chk("meta", 64'(rmeta), 64'(m_meta));
    chk("sticky", 64'(sticky), 64'(m_sticky));
    chk("cnt", 64'(cnt), 64'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int cnt_before;
    rst = 1'b1; mask = '0; irq = '0; code = '0; addr = '0; meta = '0;
    ovf = '0; ovf_clr = '0; ready = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_pop", 64'(pop), 64'(0));
    chk("rst_unit", 64'(unit), 64'(0));
    chk("rst_code", 64'(rcode), 64'(0));
    chk("rst_addr", 64'(raddr), 64'(0));
    chk("rst_sticky", 64'(sticky), 64'(0));
    chk("rst_cnt", 64'(cnt), 64'(0));
    rst = 1'b0;

    // Single error from unit 2
    @(posedge clk); #1;
    irq = 4'b0100; code[2] = 3'b101; addr[2] = 48'h1000;
    #1;
    chk("se_pop", 64'(pop), 64'(4'b0100));
    cycle();
    irq = '0;
    chk("se_valid", 64'(valid), 64'(1));
    chk("se_unit", 64'(unit), 64'(2));
    chk("se_code", 64'(rcode), 64'(5));
    chk("se_addr", 64'(raddr), 64'(48'h1000));
    ready = 1'b1;
    cycle();
    chk("se_cnt", 64'(cnt), 64'(1));

    // Round-robin from reset with everything pending
    do_reset();
    irq = 4'b1111; ready = 1'b1; accq.delete();
    repeat (10) begin
      randomize_heads();
      cycle();
    end
    chk("rr_count", 64'(accq.size()), 64'(5));
    for (int i = 0; i < 5 && i < accq.size(); i++) chk("rr_order", 64'(accq[i]), 64'(i % N));

    // Backpressure with changing heads and mask
    ready = 1'b0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      randomize_heads();
      mask = 4'($urandom);
      cycle();
    end
    mask = '0; irq = '0; ready = 1'b1;
    cnt_before = m_cnt;
    cycle();
    chk("bp_cnt", 64'(cnt), 64'(cnt_before + 1));
    cycle();
    chk("bp_idle", 64'(valid), 64'(0));

    // Masking: only units 2 and 3 may win
    mask = 4'b0011; irq = 4'b1111; ready = 1'b1; accq.delete();
    repeat (12) begin
      randomize_heads();
      cycle();
    end
    chk("mask_count", 64'(accq.size()), 64'(6));
    foreach (accq[i]) chk("mask_unit", 64'(accq[i] >= 2), 64'(1));
    mask = '0; irq = '0;
    cycle();

    // Sticky overflow
    ovf = 4'b0010;
    cycle();
    ovf = '0;
    cycle();
    chk("ovf_set", 64'(sticky[1]), 64'(1));
    ovf = 4'b0010; ovf_clr = 4'b0010;
    cycle();
    ovf = '0; ovf_clr = '0;
    chk("ovf_setwins", 64'(sticky[1]), 64'(1));
    ovf_clr = 4'b0010;
    cycle();
    ovf_clr = '0;
    chk("ovf_clr", 64'(sticky[1]), 64'(0));

    // Counter saturation then clear
    do_reset();
    irq = 4'b1111; ready = 1'b1; accq.delete();
    repeat (40) begin
      randomize_heads();
      cycle();
    end
    chk("sat_accepts", 64'(accq.size()), 64'(20));
    chk("sat_cnt", 64'(cnt), 64'(15));
    irq = '0; cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("clr_cnt", 64'(cnt), 64'(0));

    // Clear beats a same-cycle accept
    irq = 4'b0001; ready = 1'b0;
    cycle();
    irq = '0; ready = 1'b1; cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    chk("clr_wins", 64'(cnt), 64'(0));

    // Randomized phase
    for (int i = 0; i < 300; i++) begin
      mask    = 4'($urandom) & 4'($urandom);
      irq     = 4'($urandom);
      ready   = ($urandom % 3) != 0;
      ovf     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      ovf_clr = 4'($urandom) & 4'($urandom);
      cnt_clr = ($urandom % 40) == 0;
      randomize_heads();
      cycle();
    end
    mask = '0; ovf = '0; ovf_clr = '0; cnt_clr = 1'b0;

    // Reset mid-HOLD drops valid without a clock edge
    irq = 4'b0001; ready = 1'b0;
    if (m_hold) begin
      ready = 1'b1;
      cycle();
      ready = 1'b0;
    end
    cycle();
    irq = '0;
    chk("hold_before_rst", 64'(valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(valid), 64'(0));
    chk("async_rst_pop", 64'(pop), 64'(0));
    chk("async_rst_cnt", 64'(cnt), 64'(0));
    rst = 1'b0;
    model_reset();
    cycle();
    chk("post_rst_idle", 64'(valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
